// File: rtl/cache_tag_ctrl.sv
// cache_tag_ctrl: tag/valid/LRU lookup stage for a 2-way set-associative
// 2 KB cache (64 sets, 16 B blocks), sitting upstream of the fill FSM.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/addr    lookup request; addr is held stable while stall=1
//   flush             one-cycle pulse, invalidates every line
//   write_tag_array   from fill FSM: block written, install the tag
//   fsm_busy          from fill FSM: observational only
//   hit, hit_way      combinational lookup result (IDLE only)
//   stall             pipeline stall
//   miss_detected     one-cycle pulse to the fill FSM
//   miss_address      block-aligned miss address, held until the next miss
//   fill_err          sticky watchdog error, cleared by flush
//   hit_count,
//   miss_count        saturating statistics
//
// Build option: define CACHE_STATS_EN to enable the hit/miss counters;
// otherwise both counters are tied to zero.
module cache_tag_ctrl #(
  parameter int unsigned TAG_W        = 6,
  parameter int unsigned SET_W        = 6,
  parameter int unsigned OFF_W        = 4,
  parameter int unsigned FILL_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [15:0] req_addr,
  input  logic        flush,
  input  logic        write_tag_array,
  input  logic        fsm_busy,
  output logic        hit,
  output logic        hit_way,
  output logic        stall,
  output logic        miss_detected,
  output logic [15:0] miss_address,
  output logic        fill_err,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);
  localparam int unsigned SETS = 1 << SET_W;

  typedef enum logic [1:0] {IDLE, MISS, WAIT_FILL, REPLAY} state_t;
  state_t state;

  logic [SETS-1:0]  valid0, valid1, lru;
  logic [TAG_W-1:0] tag0 [SETS];
  logic [TAG_W-1:0] tag1 [SETS];

  logic [SET_W-1:0] req_set, miss_set;
  logic [TAG_W-1:0] req_tag, miss_tag;
  logic             victim, next_victim, flush_pend;
  logic [15:0]      wd_cnt;
  logic             match0, match1, go_miss, wd_expire, idle_flush;
  logic             unused_inputs;

  assign req_set = req_addr[OFF_W +: SET_W];
  assign req_tag = req_addr[OFF_W+SET_W +: TAG_W];
  assign unused_inputs = ^{fsm_busy, req_addr[OFF_W-1:0]};

  assign match0  = valid0[req_set] && (tag0[req_set] == req_tag);
  assign match1  = valid1[req_set] && (tag1[req_set] == req_tag);
  // A flush in the same cycle forces the request down the miss path.
  assign hit     = (state == IDLE) && req_valid && !flush && (match0 || match1);
  assign hit_way = hit && !match0;
  assign stall   = (state != IDLE) || (req_valid && !hit);
  assign go_miss = (state == IDLE) && req_valid && !hit;

  // Victim sees the post-flush view when a flush coincides with the miss.
  assign next_victim = flush              ? 1'b0 :
                       !valid0[req_set]   ? 1'b0 :
                       !valid1[req_set]   ? 1'b1 : lru[req_set];

  assign wd_expire = (FILL_TIMEOUT != 0) && !write_tag_array &&
                     (wd_cnt == 16'(FILL_TIMEOUT - 1));

  // Pending or coincident flush is applied on the edge that re-enters IDLE,
  // which also wipes a line installed on the preceding edge.
  assign idle_flush = flush_pend || flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      valid0        <= '0;
      valid1        <= '0;
      lru           <= '0;
      miss_set      <= '0;
      miss_tag      <= '0;
      victim        <= 1'b0;
      flush_pend    <= 1'b0;
      wd_cnt        <= '0;
      miss_detected <= 1'b0;
      miss_address  <= '0;
      fill_err      <= 1'b0;
    end else begin
      miss_detected <= 1'b0;
      if (flush) fill_err <= 1'b0;
      if (flush && state != IDLE) flush_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (flush) begin
            valid0 <= '0;
            valid1 <= '0;
            lru    <= '0;
          end else if (hit) begin
            lru[req_set] <= ~hit_way;
          end
          if (go_miss) begin
            state         <= MISS;
            miss_set      <= req_set;
            miss_tag      <= req_tag;
            victim        <= next_victim;
            miss_detected <= 1'b1;
            miss_address  <= {req_addr[15:OFF_W], {OFF_W{1'b0}}};
          end
        end
        MISS: begin
          state  <= WAIT_FILL;
          wd_cnt <= '0;
        end
        WAIT_FILL: begin
          wd_cnt <= wd_cnt + 16'd1;
          if (write_tag_array) begin
            if (victim) valid1[miss_set] <= 1'b1;
            else        valid0[miss_set] <= 1'b1;
            lru[miss_set] <= ~victim;
            state         <= REPLAY;
          end else if (wd_expire) begin
            fill_err <= 1'b1;
            state    <= IDLE;
            if (idle_flush) begin
              valid0     <= '0;
              valid1     <= '0;
              lru        <= '0;
              flush_pend <= 1'b0;
            end
          end
        end
        REPLAY: begin
          state <= IDLE;
          if (idle_flush) begin
            valid0     <= '0;
            valid1     <= '0;
            lru        <= '0;
            flush_pend <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag storage needs no reset: valid bits gate every comparison.
  always_ff @(posedge clk) begin
    if (state == WAIT_FILL && write_tag_array) begin
      if (victim) tag1[miss_set] <= miss_tag;
      else        tag0[miss_set] <= miss_tag;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (flush) begin
      hit_count  <= '0;
      miss_count <= {15'd0, go_miss};
    end else begin
      if (hit && hit_count != '1)      hit_count  <= hit_count + 16'd1;
      if (go_miss && miss_count != '1) miss_count <= miss_count + 16'd1;
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule
